uart_rx_sampler: RTL and testbench



---
 rtl/uart_rx_sampler.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// UART receive stage: 2-flop rx synchronizer, mid-bit oversampled 8N1 framing, valid/ready output.
// Optional parity bit between data and stop is enabled by defining RX_PARITY_EN.
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_error,
  output logic                 overrun_error,
  output logic                 parity_error
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_sampler: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_wait_high;
  logic                 r_done;
  logic                 r_stop_bit;
  logic                 w_cnt_half;
  logic                 w_cnt_last;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_idx_clr;
  logic                 w_shift_en;
  logic                 w_stop_en;
  logic                 w_par_ok;

  assign w_cnt_half = (r_cnt == CNT_HALF);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (baud_tick) begin
      case (r_state)
        S_IDLE:   if (!r_rx_s && !r_wait_high) w_state_nxt = S_START;
        S_START:  if (w_cnt_half) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
`ifdef RX_PARITY_EN
        S_DATA:   if (w_cnt_last && r_bit_idx == IDX_LAST) w_state_nxt = S_PARITY;
`else
        S_DATA:   if (w_cnt_last && r_bit_idx == IDX_LAST) w_state_nxt = S_STOP;
`endif
        S_PARITY: if (w_cnt_last) w_state_nxt = S_STOP;
        S_STOP:   if (w_cnt_last) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_idx_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_stop_en  = 1'b0;
    if (baud_tick) begin
      case (r_state)
        S_START: begin
          w_cnt_clr = w_cnt_half;
          w_cnt_inc = !w_cnt_half;
          w_idx_clr = w_cnt_half;
        end
        S_DATA: begin
          w_cnt_clr  = w_cnt_last;
          w_cnt_inc  = !w_cnt_last;
          w_shift_en = w_cnt_last;
        end
        S_PARITY: begin
          w_cnt_clr = w_cnt_last;
          w_cnt_inc = !w_cnt_last;
        end
        S_STOP: begin
          w_cnt_clr = w_cnt_last;
          w_cnt_inc = !w_cnt_last;
          w_stop_en = w_cnt_last;
        end
        default: w_cnt_clr = 1'b1;
      endcase
    end
  end

`ifdef RX_PARITY_EN
  logic r_par_bit;

  // Even sense: parity bit equals XOR of the data; odd sense inverts it.
  assign w_par_ok = (r_par_bit == ((^r_shift) ^ 1'(PARITY_ODD)));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_par_bit    <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      if (baud_tick && r_state == S_PARITY && w_cnt_last) r_par_bit <= r_rx_s;
      parity_error <= r_done && r_stop_bit && !w_par_ok;
    end
  end
`else
  assign w_par_ok     = 1'b1;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_rx_meta     <= 1'b1;
      r_rx_s        <= 1'b1;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_wait_high   <= 1'b0;
      r_done        <= 1'b0;
      r_stop_bit    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;

      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);

      if (w_idx_clr)       r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + IW'(1);

      if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};

      r_done <= w_stop_en;
      if (w_stop_en) r_stop_bit <= r_rx_s;

      // A low stop bit may be a break; hold off new starts until the line is seen high.
      if (w_stop_en && !r_rx_s)                          r_wait_high <= 1'b1;
      else if (baud_tick && r_state == S_IDLE && r_rx_s) r_wait_high <= 1'b0;

      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (r_done) begin
        if (!r_stop_bit) begin
          frame_error <= 1'b1;
        end else if (w_par_ok) begin
          if (!rx_valid || rx_ready) begin
            rx_data  <= r_shift;
            rx_valid <= 1'b1;
          end else begin
            overrun_error <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed and randomized frames against a frame-level model; define RX_PARITY_EN to cover parity.
module tb_uart_rx_sampler;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_ODD = 0;
`ifdef RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic       clk_in;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun_error;
  logic       parity_error;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0, tick_n = 0, watch_tick = -1, watch_cyc = -1, rise_cyc = -1;
  int n_got = 0, n_vcyc = 0, n_fe = 0, n_oe = 0, n_pe = 0;
  logic prev_v = 1'b0;
  logic [7:0] got_mem [0:255];
  logic [7:0] exp_q [$];
  int b_got, b_v, b_fe, b_oe, b_pe;

  uart_rx_sampler #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_error  (frame_error),
    .overrun_error(overrun_error),
    .parity_error (parity_error)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk_in);
      #1 baud_tick = 1'b1;
      @(posedge clk_in);
      #1 baud_tick = 1'b0;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk_in) begin
    cyc = cyc + 1;
    if (baud_tick) begin
      tick_n = tick_n + 1;
      if (tick_n == watch_tick) watch_cyc = cyc;
    end
  end

  always @(negedge clk_in) begin
    if (rx_valid && rx_ready) begin
      got_mem[n_got % 256] = rx_data;
      n_got = n_got + 1;
    end
    if (rx_valid) n_vcyc = n_vcyc + 1;
    if (rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_valid;
    if (frame_error)   n_fe = n_fe + 1;
    if (overrun_error) n_oe = n_oe + 1;
    if (parity_error)  n_pe = n_pe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_got = n_got; b_v = n_vcyc; b_fe = n_fe; b_oe = n_oe; b_pe = n_pe;
  endtask

  task automatic chk_counts(input string tag, input int got, input int fe, input int oe, input int pe);
    chk({tag, "_got"}, n_got - b_got, got);
    chk({tag, "_fe"},  n_fe - b_fe, fe);
    chk({tag, "_oe"},  n_oe - b_oe, oe);
    chk({tag, "_pe"},  n_pe - b_pe, pe);
  endtask

  task automatic wait_tick();
    do @(posedge clk_in); while (baud_tick !== 1'b1);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  // Holds the line at b for one bit period, starting just after a tick edge.
  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(OVERSAMPLE);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    wait_tick();
    #1;
    // Start is seen on the next tick; stop is sampled half a bit into the last bit period.
    watch_tick = tick_n + 1 + OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + NPAR + 1);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i]);
    if (NPAR != 0) drive_bit(par_bit);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    logic [31:0] sense;
    sense = PARITY_ODD;
    return (^d) ^ sense[0];
  endfunction

  initial begin
    int b_pre;
    int efe, epe;
    logic [7:0] d;
    logic bs, bp;

    rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    chk("rst_oe", overrun_error, 1'b0);
    chk("rst_pe", parity_error, 1'b0);
    @(posedge clk_in);
    #1 rst = 1'b0;
    wait_ticks(4);

    // Plain frame, latency and single-cycle valid with consumer ready
    snap();
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    wait_ticks(4);
    chk_counts("a5", 1, 0, 0, 0);
    chk("a5_data", got_mem[b_got % 256], 8'hA5);
    chk("a5_vcyc", n_vcyc - b_v, 1);
    chk("a5_lat", rise_cyc, watch_cyc + 1);

    // Short low pulse is rejected at mid start bit
    snap();
    wait_tick(); #1 rx = 1'b0;
    wait_ticks(5); #1 rx = 1'b1;
    wait_ticks(40);
    chk_counts("glitch", 0, 0, 0, 0);
    chk("glitch_vcyc", n_vcyc - b_v, 0);

    // Framing error then recovery
    snap();
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    wait_ticks(8);
    chk_counts("fe3c", 0, 1, 0, 0);
    chk("fe3c_vcyc", n_vcyc - b_v, 0);
    snap();
    send_frame(8'h81, 1'b1, good_par(8'h81));
    wait_ticks(4);
    chk_counts("r81", 1, 0, 0, 0);
    chk("r81_data", got_mem[b_got % 256], 8'h81);

    // Overrun while consumer stalls
    #1 rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, good_par(8'h11));
    wait_ticks(2);
    send_frame(8'h22, 1'b1, good_par(8'h22));
    wait_ticks(4);
    @(negedge clk_in);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1'b1);
    chk_counts("ovr", 0, 0, 1, 0);
    @(posedge clk_in);
    #1 rx_ready = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("ovr_clear", rx_valid, 1'b0);
    chk("ovr_acc_n", n_got - b_got, 1);
    chk("ovr_acc_d", got_mem[b_got % 256], 8'h11);
    wait_ticks(2);

    // Reset mid-frame drops pending byte and partial frame
    #1 rx_ready = 1'b0;
    b_pre = n_got;
    send_frame(8'h5A, 1'b1, good_par(8'h5A));
    wait_ticks(2);
    @(negedge clk_in);
    chk("pend_valid", rx_valid, 1'b1);
    chk("pend_data", rx_data, 8'h5A);
    wait_tick(); #1 rx = 1'b0;
    wait_ticks(OVERSAMPLE); #1 rx = 1'b1;
    wait_ticks(OVERSAMPLE * 4 + OVERSAMPLE / 2);
    #1 rst = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_valid", rx_valid, 1'b0);
    chk("mrst_errs", {frame_error, overrun_error, parity_error}, 3'b000);
    @(posedge clk_in);
    #1 rst = 1'b0; rx_ready = 1'b1;
    wait_ticks(100);
    snap();
    send_frame(8'h55, 1'b1, good_par(8'h55));
    wait_ticks(4);
    chk_counts("r55", 1, 0, 0, 0);
    chk("r55_data", got_mem[b_got % 256], 8'h55);
    chk("r55_only", n_got - b_pre, 1);

`ifdef RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_ticks(4);
    chk_counts("par_ok", 1, 0, 0, 0);
    chk("par_ok_data", got_mem[b_got % 256], 8'h07);
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    wait_ticks(4);
    chk_counts("par_bad", 0, 0, 0, 1);
    chk("par_bad_vcyc", n_vcyc - b_v, 0);
`endif

    // Randomized frames, occasional bad stop or parity
    snap();
    exp_q.delete();
    efe = 0; epe = 0;
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom_range(0, 255));
      bs = ($urandom_range(0, 3) == 0);
      bp = (NPAR != 0) && ($urandom_range(0, 3) == 0);
      send_frame(d, !bs, good_par(d) ^ bp);
      if (bs)      efe++;
      else if (bp) epe++;
      else         exp_q.push_back(d);
      wait_ticks($urandom_range(2, 24));
    end
    wait_ticks(4);
    chk_counts("rnd", exp_q.size(), efe, 0, epe);
    chk("rnd_vcyc", n_vcyc - b_v, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_byte%0d", i), got_mem[(b_got + i) % 256], exp_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
